veririsc_sequencer: RTL and testbench

- Multi-cycle control unit for the VeriRISC core: an 8-phase instruction cycle that drives PC, IR, accumulator, memory strobes and the 3-bit op select of the 8-bit ALU.
- Decodes the 3-bit opcode from the IR and the ALU zero flag.
- Stretches fetch phases on memory wait states and halts on HLT or on a memory timeout.

---
 rtl/veririsc_sequencer.sv | 179 +++++++++++++++++
 tb/tb_veririsc_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/veririsc_sequencer.sv
// VeriRISC multi-cycle sequencer: 8-phase instruction cycle with memory wait-state stretching and timeout halt.
// Optional retired-instruction counter enabled by defining VERIRISC_SEQ_INSTR_COUNT_EN.
module veririsc_sequencer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             wr,
  output logic             data_e,
  output logic [2:0]       alu_op,
  output logic             alu_a_zero,
  output logic             halt,
  output logic             bus_error,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

  phase_e     state;
  logic       halted;
  logic       bus_err_q;
  logic [7:0] wait_cnt;

  opcode_e op;
  logic    aluop;
  logic    stall_phase;
  logic    take_hlt;

  assign op = opcode_e'(opcode);

  always_comb begin
    aluop       = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    // Only ALU-class instructions read memory in OP_FETCH, so only they can stall there.
    stall_phase = !halted && ((state == INST_FETCH) || ((state == OP_FETCH) && aluop));
    take_hlt    = !halted && (state == OP_ADDR) && (op == OP_HLT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INST_ADDR;
      halted    <= 1'b0;
      bus_err_q <= 1'b0;
      wait_cnt  <= 8'd0;
    end else if (!halted) begin
      if (stall_phase) begin
        // A ready on the limit edge still wins over the timeout.
        if (mem_ready) begin
          state    <= phase_e'(state + 3'd1);
          wait_cnt <= 8'd0;
        end else if (wait_cnt == WAIT_LIMIT) begin
          bus_err_q <= 1'b1;
          halted    <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end else if (take_hlt) begin
        halted <= 1'b1;
      end else begin
        state <= phase_e'(state + 3'd1);
      end
    end
  end

`ifdef VERIRISC_SEQ_INSTR_COUNT_EN
  logic             retire;
  logic [CNT_W-1:0] count_q;

  assign retire = take_hlt || (!halted && (state == STORE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    sel        = 1'b0;
    rd         = 1'b0;
    ld_ir      = 1'b0;
    inc_pc     = 1'b0;
    ld_pc      = 1'b0;
    ld_ac      = 1'b0;
    wr         = 1'b0;
    data_e     = 1'b0;
    alu_op     = 3'b000;
    alu_a_zero = 1'b0;
    if (halted) begin
      sel = 1'b1;
    end else begin
      unique case (state)
        INST_ADDR: sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: inc_pc = 1'b1;
        OP_FETCH: rd = aluop;
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (op == OP_SKZ) && zero;
          ld_pc  = (op == OP_JMP);
          data_e = (op == OP_STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (op == OP_JMP);
          wr     = (op == OP_STO);
          data_e = (op == OP_STO);
        end
        default: sel = 1'b1;
      endcase

      if (state >= OP_FETCH) begin
        unique case (op)
          OP_AND:  alu_op = 3'b010;
          OP_XOR:  alu_op = 3'b100;
          OP_LDA: begin
            alu_op     = 3'b011;
            alu_a_zero = 1'b1;
          end
          default: alu_op = 3'b000;
        endcase
      end
    end
  end

  assign halt      = halted;
  assign bus_error = bus_err_q;
  assign phase     = state;

endmodule

// File: tb/tb_veririsc_sequencer.sv
// Self-checking bench for veririsc_sequencer: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the instruction cycle.
module tb_veririsc_sequencer;

  localparam int MEM_WAIT_MAX = 15;
  localparam int CNT_W        = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       opcode = 3'd0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b1;
  logic             sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e;
  logic [2:0]       alu_op;
  logic             alu_a_zero, halt, bus_error;
  logic [2:0]       phase;
  logic [CNT_W-1:0] instr_count;

  veririsc_sequencer #(.MEM_WAIT_MAX(MEM_WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc), .ld_ac(ld_ac),
    .wr(wr), .data_e(data_e), .alu_op(alu_op), .alu_a_zero(alu_a_zero), .halt(halt),
    .bus_error(bus_error), .phase(phase), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: position within the instruction cycle and retirement count.
  int          m_phase;
  int          m_wait;
  bit          m_halted;
  bit          m_berr;
  int unsigned m_count;
  int          inc_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_aluop(input int op);
    return (op == 2) || (op == 3) || (op == 4) || (op == 5);
  endfunction

  // {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,alu_op,alu_a_zero,halt,bus_error,phase}
  function automatic logic [16:0] expected_out(input int op, input bit z);
    bit         e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_az;
    logic [2:0] e_aop;
    bit         alu_class;
    if (m_halted)
      return {1'b1, 7'b0, 3'b000, 1'b0, 1'b1, m_berr, 3'(m_phase)};
    alu_class = is_aluop(op);
    e_sel  = (m_phase <= 3);
    e_rd   = (m_phase >= 1 && m_phase <= 3) || (m_phase >= 5 && alu_class);
    e_ldir = (m_phase == 2) || (m_phase == 3);
    e_inc  = (m_phase == 4) || (m_phase == 6 && op == 1 && z);
    e_ldpc = (m_phase >= 6) && (op == 7);
    e_ldac = (m_phase == 7) && alu_class;
    e_wr   = (m_phase == 7) && (op == 6);
    e_de   = (m_phase >= 6) && (op == 6);
    e_aop  = 3'b000;
    e_az   = 1'b0;
    if (m_phase >= 5) begin
      if (op == 3) e_aop = 3'b010;
      if (op == 4) e_aop = 3'b100;
      if (op == 5) begin
        e_aop = 3'b011;
        e_az  = 1'b1;
      end
    end
    return {e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_aop, e_az, 1'b0, m_berr,
            3'(m_phase)};
  endfunction

  function automatic logic [CNT_W-1:0] expected_count();
`ifdef VERIRISC_SEQ_INSTR_COUNT_EN
    return CNT_W'(m_count);
`else
    return '0;
`endif
  endfunction

  function automatic logic [16:0] dut_out();
    return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, alu_op, alu_a_zero, halt,
            bus_error, phase};
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_wait   = 0;
    m_halted = 0;
    m_berr   = 0;
    m_count  = 0;
  endtask

  // One clock edge of the instruction cycle as seen from outside.
  task automatic model_edge(input int op, input bit mr);
    bit waits_for_mem;
    if (m_halted) return;
    waits_for_mem = (m_phase == 1) || (m_phase == 5 && is_aluop(op));
    if (waits_for_mem && !mr) begin
      if (m_wait >= MEM_WAIT_MAX) begin
        m_berr   = 1;
        m_halted = 1;
      end else begin
        m_wait++;
      end
    end else if (m_phase == 4 && op == 0) begin
      m_halted = 1;
      m_count++;
    end else begin
      m_wait = 0;
      if (m_phase == 7) m_count++;
      m_phase = (m_phase + 1) % 8;
    end
  endtask

  // Called just after a rising edge; leaves time just after the next rising edge.
  task automatic step(input int op, input bit z, input bit mr);
    opcode    = 3'(op);
    zero      = z;
    mem_ready = mr;
    #1;
    check($sformatf("out_p%0d_op%0d", m_phase, op), 32'(dut_out()), 32'(expected_out(op, z)));
    check("instr_count", 32'(instr_count), 32'(expected_count()));
    if (inc_pc) inc_seen++;
    @(posedge clk);
    model_edge(op, mr);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_out", 32'(dut_out()), 32'h10000);
    check("rst_count", 32'(instr_count), 32'd0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int stalls;
    int cur_op;
    int burst;
    int halted_cycles;
    model_reset();
    inc_seen = 0;

    #3;
    check("rst_init_out", 32'(dut_out()), 32'h10000);
    check("rst_init_count", 32'(instr_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ADD with no wait states: eight phases, back at phase 0.
    for (int i = 0; i < 8; i++) step(2, 0, 1);
    check("add_latency_phase", 32'(phase), 32'd0);

    // SKZ skips twice when zero is set, once otherwise.
    inc_seen = 0;
    for (int i = 0; i < 8; i++) step(1, 1, 1);
    check("skz_z1_incs", 32'(inc_seen), 32'd2);
    inc_seen = 0;
    for (int i = 0; i < 8; i++) step(1, 0, 1);
    check("skz_z0_incs", 32'(inc_seen), 32'd1);

    for (int i = 0; i < 8; i++) step(6, 0, 1);
    for (int i = 0; i < 8; i++) step(7, 1, 1);
    for (int i = 0; i < 8; i++) step(5, 0, 1);
    for (int i = 0; i < 8; i++) step(3, 0, 1);
    for (int i = 0; i < 8; i++) step(4, 1, 1);

    // Three wait states in INST_FETCH stretch the instruction to 11 cycles.
    stalls = 0;
    for (int i = 0; i < 11; i++) begin
      if (m_phase == 1 && stalls < 3) begin
        stalls++;
        step(2, 0, 0);
      end else begin
        step(2, 0, 1);
      end
    end
    check("stall_latency_phase", 32'(phase), 32'd0);
    check("stall_no_error", 32'(bus_error), 32'd0);

    // Memory never ready in OP_FETCH: timeout after MEM_WAIT_MAX+1 stalled cycles.
    stalls = 0;
    for (int i = 0; i < 40 && !m_halted; i++) begin
      if (m_phase == 5) stalls++;
      step(2, 0, (m_phase != 5));
    end
    check("timeout_stalls", 32'(stalls), 32'(MEM_WAIT_MAX + 1));
    check("timeout_bus_error", 32'(bus_error), 32'd1);
    check("timeout_halt", 32'(halt), 32'd1);
    check("timeout_phase", 32'(phase), 32'd5);
    for (int i = 0; i < 4; i++) step($urandom_range(0, 7), 1'($urandom), 1'($urandom));
    do_reset();

    // HLT stops in OP_ADDR and retires one instruction.
    for (int i = 0; i < 10 && !m_halted; i++) step(0, 0, 1);
    check("hlt_halt", 32'(halt), 32'd1);
    check("hlt_phase", 32'(phase), 32'd4);
`ifdef VERIRISC_SEQ_INSTR_COUNT_EN
    check("hlt_count", 32'(instr_count), 32'd1);
`else
    check("hlt_count", 32'(instr_count), 32'd0);
`endif
    for (int i = 0; i < 4; i++) step($urandom_range(0, 7), 1'($urandom), 1'($urandom));
    do_reset();

    // Reset in the middle of phase 6 takes effect without a clock edge.
    for (int i = 0; i < 8; i++) step(6, 0, 1);
    for (int i = 0; i < 10 && m_phase != 6; i++) step(6, 0, 1);
    check("pre_rst_phase", 32'(phase), 32'd6);
    do_reset();

    // Randomized traffic: opcode held per instruction, occasional long memory stalls.
    cur_op        = 2;
    burst         = 0;
    halted_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      bit mr;
      if (m_halted) begin
        halted_cycles++;
        if (halted_cycles > 3) begin
          do_reset();
          halted_cycles = 0;
        end
      end
      if (m_phase == 0 && !m_halted) begin
        cur_op = $urandom_range(0, 7);
        if (cur_op == 0 && $urandom_range(0, 3) != 0) cur_op = 2;
      end
      if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(10, 20);
      if (burst > 0) begin
        burst--;
        mr = 1'b0;
      end else begin
        mr = ($urandom_range(0, 9) != 0);
      end
      step(cur_op, 1'($urandom), mr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
